// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the instruction memory address,
// and pairs each returned word with its PC for decode (stall replay, redirect flush, fault trap).
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [31:0] MAX_PC = 32'(MEM_SIZE - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_vld_q, req_vld_d;
    logic        fault_d;
    logic        bad_pc;

    assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q > MAX_PC);

    // Replaying the held address makes memory re-present the same word while stalled.
    // In FAULT req_vld_q is always 0, so this collapses to pc_q there.
    assign imem_addr = (stall && req_vld_q && !redirect_valid) ? req_pc_q : pc_q;
    assign if_valid  = req_vld_q && !redirect_valid;
    assign if_pc     = req_pc_q;
    assign if_instr  = imem_instr;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_vld_d = req_vld_q;
        fault_d   = fetch_fault;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d      = redirect_pc;
                    req_vld_d = 1'b0;
                end else if (stall && req_vld_q) begin
                    pc_d = pc_q;
                end else if (bad_pc) begin
                    fault_d   = 1'b1;
                    req_vld_d = 1'b0;
                    state_d   = FAULT;
                end else begin
                    req_pc_d  = pc_q;
                    req_vld_d = 1'b1;
                    pc_d      = pc_q + 32'd4;
                end
            end
            FAULT: begin
                // Target is re-checked by the FETCH rules on the following cycle.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    fault_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0;
            req_vld_q   <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_vld_q   <= req_vld_d;
            fetch_fault <= fault_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
        end else if (if_valid && !stall) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with a 1-cycle-latency instruction memory model.
module tb_imem_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int tests_run;
    int tests_failed;

    logic [31:0] mem [64];

    imem_fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(256)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read: word for the address seen at this edge appears after it.
    always @(posedge clk) imem_instr <= mem[imem_addr[7:2]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        next_cycle();
        next_cycle();
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_if_pc: got %h expected 00000000", if_pc); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_imem_addr: got %h expected 00000000", imem_addr); end
        tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
        tests_run++; if (fetch_count !== 32'h0) begin tests_failed++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
        rst_n = 1'b1;
    endtask

    // Cycles 1..3 deliver PCs 0,4,8; cycle 4 shows PC 12 with three accepted.
    task automatic test_sequential();
        next_cycle();
        tests_run++; if (if_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_first_valid: got %b expected 1", if_valid); end
        tests_run++; if (if_pc !== 32'h0) begin tests_failed++; $display("FAIL seq_pc0: got %h expected 00000000", if_pc); end
        tests_run++; if (if_instr !== 32'hA000_0000) begin tests_failed++; $display("FAIL seq_instr0: got %h expected a0000000", if_instr); end
        next_cycle();
        tests_run++; if (if_pc !== 32'h4 || if_instr !== 32'hA000_0001) begin tests_failed++; $display("FAIL seq_pc4: got pc %h instr %h expected 00000004 a0000001", if_pc, if_instr); end
        next_cycle();
        tests_run++; if (if_pc !== 32'h8 || if_instr !== 32'hA000_0002) begin tests_failed++; $display("FAIL seq_pc8: got pc %h instr %h expected 00000008 a0000002", if_pc, if_instr); end
        next_cycle();
        tests_run++; if (fetch_count !== 32'd3) begin tests_failed++; $display("FAIL seq_count: got %0d expected 3", fetch_count); end
        tests_run++; if (if_pc !== 32'hC || if_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_pc12: got pc %h valid %b expected 0000000c 1", if_pc, if_valid); end
    endtask

    // Stall three cycles while PC 12 is presented; replay keeps the same word.
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL stall_addr[%0d]: got %h expected 0000000c", i, imem_addr); end
            tests_run++; if (if_pc !== 32'hC || if_instr !== 32'hA000_0003 || if_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold[%0d]: got pc %h instr %h valid %b expected 0000000c a0000003 1", i, if_pc, if_instr, if_valid); end
            tests_run++; if (fetch_count !== 32'd3) begin tests_failed++; $display("FAIL stall_count[%0d]: got %0d expected 3", i, fetch_count); end
            next_cycle();
        end
        stall = 1'b0;
        #1;
        tests_run++; if (if_pc !== 32'hC || imem_addr !== 32'h10) begin tests_failed++; $display("FAIL stall_release: got pc %h addr %h expected 0000000c 00000010", if_pc, imem_addr); end
        next_cycle();
        tests_run++; if (if_pc !== 32'h10 || if_instr !== 32'hA000_0004 || fetch_count !== 32'd4) begin tests_failed++; $display("FAIL stall_after: got pc %h instr %h count %0d expected 00000010 a0000004 4", if_pc, if_instr, fetch_count); end
    endtask

    // Redirect to 0x40 together with stall while PC 0x10 is presented.
    task automatic test_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_same_cycle_valid: got %b expected 0", if_valid); end
        tests_run++; if (imem_addr !== 32'h14) begin tests_failed++; $display("FAIL redir_same_cycle_addr: got %h expected 00000014", imem_addr); end
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        // Stall with nothing in flight must not hold the target fetch.
        tests_run++; if (if_valid !== 1'b0 || imem_addr !== 32'h40) begin tests_failed++; $display("FAIL redir_gap: got valid %b addr %h expected 0 00000040", if_valid, imem_addr); end
        next_cycle();
        stall = 1'b0;
        #1;
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hA000_0010) begin tests_failed++; $display("FAIL redir_target: got valid %b pc %h instr %h expected 1 00000040 a0000010", if_valid, if_pc, if_instr); end
        tests_run++; if (fetch_count !== 32'd4) begin tests_failed++; $display("FAIL redir_count_frozen: got %0d expected 4", fetch_count); end
        next_cycle();
        tests_run++; if (if_pc !== 32'h44 || fetch_count !== 32'd5) begin tests_failed++; $display("FAIL redir_next: got pc %h count %0d expected 00000044 5", if_pc, fetch_count); end
    endtask

    // Misaligned target faults; a good redirect recovers two cycles later.
    task automatic test_misaligned_fault();
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        tests_run++; if (if_valid !== 1'b0 || fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL fault_pending: got valid %b fault %b expected 0 0", if_valid, fetch_fault); end
        next_cycle();
        tests_run++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL fault_set: got fault %b valid %b expected 1 0", fetch_fault, if_valid); end
        tests_run++; if (dut.state_q !== 1'b1) begin tests_failed++; $display("FAIL fault_state: got %b expected 1", dut.state_q); end
        stall = 1'b1;
        next_cycle();
        tests_run++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h42) begin tests_failed++; $display("FAIL fault_hold: got fault %b valid %b addr %h expected 1 0 00000042", fetch_fault, if_valid, imem_addr); end
        stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        tests_run++; if (fetch_fault !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h20) begin tests_failed++; $display("FAIL fault_clear: got fault %b valid %b addr %h expected 0 0 00000020", fetch_fault, if_valid, imem_addr); end
        next_cycle();
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== 32'hA000_0008) begin tests_failed++; $display("FAIL fault_recover: got valid %b pc %h instr %h expected 1 00000020 a0000008", if_valid, if_pc, if_instr); end
    endtask

    // Run off the top of memory: 0xFC is the last legal fetch.
    task automatic test_range_end();
        redirect_valid = 1'b1; redirect_pc = 32'hF4;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        tests_run++; if (if_pc !== 32'hF4 || if_valid !== 1'b1) begin tests_failed++; $display("FAIL end_pc_f4: got pc %h valid %b expected 000000f4 1", if_pc, if_valid); end
        next_cycle();
        next_cycle();
        tests_run++; if (if_pc !== 32'hFC || if_valid !== 1'b1 || fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL end_last: got pc %h valid %b fault %b expected 000000fc 1 0", if_pc, if_valid, fetch_fault); end
        next_cycle();
        tests_run++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL end_fault: got fault %b valid %b addr %h expected 1 0 00000100", fetch_fault, if_valid, imem_addr); end
    endtask

    // Async reset in the middle of a stall at PC 0x30, then restart at RESET_PC.
    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h28;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        tests_run++; if (if_pc !== 32'h30 || if_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_setup: got pc %h valid %b expected 00000030 1", if_pc, if_valid); end
        stall = 1'b1;
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL areset_outputs: got valid %b pc %h addr %h expected 0 00000000 00000000", if_valid, if_pc, imem_addr); end
        tests_run++; if (fetch_count !== 32'h0 || fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL areset_regs: got count %0d fault %b expected 0 0", fetch_count, fetch_fault); end
        stall = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        tests_run++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA000_0000) begin tests_failed++; $display("FAIL areset_restart: got valid %b pc %h instr %h expected 1 00000000 a0000000", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        imem_instr = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned_fault();
        test_range_end();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Initiator/reader side of the instruction memory port: owns the PC, drives the byte address, and consumes the instruction word that the memory registers one clock later.
- Delivers a valid/pc/instr triple to decode.
- Handles stall by replaying the held address, handles branch/jump redirects by flushing, and detects misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_SIZE, 256, instruction memory size in bytes; legal fetch addresses are 0..MEM_SIZE-4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction memory.
- imem_instr  in  32  instruction word registered by memory at the previous posedge.
- stall  in  1  decode cannot accept the current instruction.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target.
- if_valid  out  1  if_pc/if_instr hold a valid fetched instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  instruction to decode; driven directly from imem_instr.
- fetch_fault  out  1  sticky flag: fetch address misaligned or out of range.
- fetch_count  out  32  number of instructions accepted by decode.

Behaviour:
- Memory contract: the address presented in cycle N yields the instruction on imem_instr in cycle N+1 (1-cycle latency).
- Registers and reset values (async on rst_n low, applies mid-operation): pc_q=RESET_PC, req_pc_q=0, req_vld_q=0, state=FETCH, fetch_fault=0, fetch_count=0.
- Reset outputs: if_valid=0, if_pc=0, imem_addr=RESET_PC.
- imem_addr = (stall && req_vld_q && !redirect_valid) ? req_pc_q : pc_q. The replay address makes memory re-present the same word during stall, so no skid buffer is needed.
- if_valid = req_vld_q && !redirect_valid; if_pc = req_pc_q; if_instr = imem_instr.
- bad_pc = (pc_q[1:0]!=0) || (pc_q > MEM_SIZE-4), unsigned compare.
- State FETCH, per posedge, priority order:
  1. redirect_valid: pc_q<=redirect_pc; req_vld_q<=0. Overrides stall; the in-flight instruction is dropped.
  2. stall && req_vld_q: all of pc_q, req_pc_q, req_vld_q hold.
  3. bad_pc: fetch_fault<=1; req_vld_q<=0; pc_q holds; state<=FAULT.
  4. Otherwise: req_pc_q<=pc_q; req_vld_q<=1; pc_q<=pc_q+4. Addition is modulo 2^32; wrap then faults via the range check.
- stall with req_vld_q=0 has no effect; fetch proceeds.
- State FAULT:
  - if_valid=0, imem_addr=pc_q, no new fetches, stall ignored.
  - On redirect_valid: pc_q<=redirect_pc; fetch_fault<=0; state<=FETCH. The target is checked by the normal FETCH rules the next cycle.
- fetch_count increments by 1 (wraps) at each posedge where if_valid && !stall.
- First valid instruction appears 1 cycle after reset release; steady-state throughput is 1 instruction/cycle.
- Redirect-to-first-valid-target latency: 2 cycles (cycle R: redirect; R+1: target address presented; R+2: if_valid=1).
- redirect_valid and stall in the same cycle: redirect wins and if_valid=0 that cycle.

Test Plan:
- Reset release, no stall, memory preloaded with words at 0,4,8 -> cycle 1: if_pc=0, cycle 2: if_pc=4, cycle 3: if_pc=8; if_valid=1 from cycle 1; fetch_count=3 after cycle 3.
- Stall held 3 cycles while if_pc=8 -> imem_addr=8 during stall; if_pc=8 and if_instr constant; fetch_count frozen; after release next if_pc=12 with no skipped or duplicated PC.
- redirect_valid with redirect_pc=0x40 while if_pc=0x10, with stall=1 in the same cycle -> if_valid=0 that cycle and next; then if_pc=0x40, 0x44 in order.
- redirect_pc=0x42 -> fetch_fault=1, state FAULT, if_valid stays 0. Later redirect_pc=0x20 -> fetch_fault=0, if_pc=0x20 two cycles later.
- Sequential run reaching pc_q=MEM_SIZE (256) -> last valid if_pc=252, then fetch_fault=1, if_valid=0.
- rst_n asserted asynchronously mid-stall at if_pc=0x30 -> outputs go to reset values immediately without a clock edge; after release, fetch restarts at RESET_PC.
